// File: rtl/uart_tx_fifo_if.sv
// Push-side handshake bundle for uart_tx_fifo: a word plus valid/ready.
// The master offers data; the slave (the transmitter FIFO) accepts when ready.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular FIFO; queued words leave back-to-back
// with configurable width, baud divisor, parity and stop-bit count.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 217,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               in_if,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  // Wide enough for both the data-bit index and the stop-bit index.
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];

  logic                    ready;
  logic                    push;
  logic                    pop;
  logic                    fifo_ne;
  logic                    baud_end;
  logic [DATA_WIDTH-1:0]   head;

  assign ready       = (count_q != CW'(FIFO_DEPTH));
  assign in_if.ready = ready;
  assign push        = in_if.valid && ready;
  assign fifo_ne     = (count_q != '0);
  assign head        = mem[rd_ptr_q];
  assign baud_end    = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] w);
    return (PARITY == 1) ? ~^w : ^w;
  endfunction

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_ne) begin
          pop     = 1'b1;
          state_d = START;
          baud_d  = '0;
          shift_d = head;
          par_d   = parity_of(head);
          tx_d    = 1'b0;
        end
      end
      START: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
            tx_d  = shift_q[1];
          end
        end
      end
      PAR: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (fifo_ne) begin
              pop     = 1'b1;
              state_d = START;
              shift_d = head;
              par_d   = parity_of(head);
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_if.data;
    end
  end

  assign tx_o    = tx_q;
  assign busy_o  = (state_q != IDLE) || fifo_ne;
  assign count_o = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Drives four uart_tx_fifo configurations in parallel and compares every cycle
// against a queue-based line model built from the frame format.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst;
  bit   gaps = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int DW  = (gi == 3) ? 7 : 8;
    localparam int PAR = (gi == 0) ? 0 : ((gi == 1) ? 1 : 2);
    localparam int SB  = (gi == 3) ? 2 : 1;

    uart_tx_fifo_if #(.DATA_WIDTH(DW)) bus ();

    logic             tx_w;
    logic             busy_w;
    logic [CNT_W-1:0] cnt_w;
    logic             vld;
    logic [DW-1:0]    dat;

    int src[$];
    int mq[$];
    bit wave[$];
    bit etx = 1'b1;
    bit inf = 1'b0;

    assign bus.valid = vld;
    assign bus.data  = dat;

    uart_tx_fifo #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB),
      .PARITY      (PAR),
      .STOP_BITS   (SB),
      .FIFO_DEPTH  (DEPTH)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .in_if  (bus),
      .tx_o   (tx_w),
      .busy_o (busy_w),
      .count_o(cnt_w)
    );

    // Upstream source: offers the head of src, holding it until accepted.
    initial begin
      vld = 1'b0;
      dat = '0;
      forever begin
        @(negedge clk);
        if (src.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          vld = 1'b1;
          dat = src[0][DW-1:0];
        end else begin
          vld = 1'b0;
        end
      end
    end

    // Line model: a frame is appended whenever the line has nothing left to send.
    initial begin
      int w;
      int ones;
      bit pb;
      bit acc;
      forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
          src.delete();
          mq.delete();
          wave.delete();
          etx = 1'b1;
          inf = 1'b0;
        end else begin
          acc = vld && (src.size() != 0) && (mq.size() != DEPTH);
          if (wave.size() == 0 && mq.size() != 0) begin
            w    = mq.pop_front();
            ones = $countones(w);
            pb   = (PAR == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
            repeat (CPB) wave.push_back(1'b0);
            for (int b = 0; b < DW; b++) repeat (CPB) wave.push_back(w[b]);
            if (PAR != 0) repeat (CPB) wave.push_back(pb);
            repeat (SB * CPB) wave.push_back(1'b1);
          end
          if (acc) mq.push_back(src.pop_front() & ((1 << DW) - 1));
          if (wave.size() != 0) begin
            etx = wave.pop_front();
            inf = 1'b1;
          end else begin
            etx = 1'b1;
            inf = 1'b0;
          end
        end
      end
    end

    initial forever begin
      @(negedge clk);
      check_eq($sformatf("cfg%0d tx_o", gi), int'(tx_w), int'(etx));
      check_eq($sformatf("cfg%0d busy/ready/count", gi), int'({busy_w, bus.ready, cnt_w}),
               (((inf || mq.size() != 0) ? 16 : 0) + ((mq.size() != DEPTH) ? 8 : 0) + mq.size()));
    end
  end

  task automatic offer_all(input int w);
    g[0].src.push_back(w);
    g[1].src.push_back(w);
    g[2].src.push_back(w);
    g[3].src.push_back(w);
  endtask

  function automatic bit all_idle();
    return g[0].src.size() == 0 && !g[0].busy_w && g[1].src.size() == 0 && !g[1].busy_w &&
           g[2].src.size() == 0 && !g[2].busy_w && g[3].src.size() == 0 && !g[3].busy_w;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle within budget", int'(n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  // Busy-cycle count of one isolated frame: acceptance cycle plus the whole frame.
  task automatic single_frame(input int w);
    int nb[4];
    nb = '{0, 0, 0, 0};
    offer_all(w);
    repeat (120) begin
      @(negedge clk);
      if (g[0].busy_w) nb[0]++;
      if (g[1].busy_w) nb[1]++;
      if (g[2].busy_w) nb[2]++;
      if (g[3].busy_w) nb[3]++;
    end
    check_eq($sformatf("cfg0 busy cycles %0h", w), nb[0], 41);
    check_eq($sformatf("cfg1 busy cycles %0h", w), nb[1], 45);
    check_eq($sformatf("cfg2 busy cycles %0h", w), nb[2], 45);
    check_eq($sformatf("cfg3 busy cycles %0h", w), nb[3], 45);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    single_frame(8'hAC);
    single_frame(8'h01);

    // Burst of six words against a four-deep FIFO.
    for (int i = 0; i < 6; i++) offer_all(i);
    wait_idle(600);

    // Second word lands around the final stop-bit cycle of the first frame.
    for (int d = 36; d <= 48; d++) begin
      offer_all($urandom_range(0, 255));
      repeat (d) @(negedge clk);
      offer_all($urandom_range(0, 255));
      wait_idle(300);
    end

    gaps = 1'b1;
    for (int i = 0; i < 60; i++) begin
      offer_all($urandom_range(0, 511));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_idle(4000);
    gaps = 1'b0;

    // Reset in the middle of DATA with two words still queued.
    offer_all(8'hF0);
    offer_all(8'h0F);
    offer_all(8'h99);
    repeat (10) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("cfg0 async reset tx", int'(g[0].tx_w), 1);
    check_eq("cfg1 async reset tx", int'(g[1].tx_w), 1);
    check_eq("cfg2 async reset tx", int'(g[2].tx_w), 1);
    check_eq("cfg3 async reset tx", int'(g[3].tx_w), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    offer_all(8'h5A);
    wait_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at t=%0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
